// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: control sequencer for the 8-bit CPU.
// Generates REG/ROM/RAM/PC/ACC strobes from a latched opcode. It also handles
// memory ready/wait with a timeout fault, multi-byte operand fetch, a resumable
// halt, and illegal-opcode trapping.
// Optional single-step mode: define CPU_CTRL_STEP_EN.
module cpu_ctrl_seq #(
    parameter int OPW        = 4,
    parameter int OPND_BYTES = 1,
    parameter int TMO        = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] ins,
    input  logic           mem_rdy,
    input  logic           resume,
    output logic           reg_write,
    output logic           reg_read,
    output logic           rom_en,
    output logic           rom_read,
    output logic           ram_en,
    output logic           ram_write,
    output logic           ram_read,
    output logic           pc_en,
    output logic           pc_chg_en,
    output logic           acc_en,
    output logic [2:0]     fetch,
    output logic           addr_sel,
    output logic           halted,
    output logic           fault
);

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_LDO = 4'h1, OP_LDA = 4'h2, OP_LDR = 4'h3,
        OP_PRE = 4'h4, OP_STO = 4'h5, OP_ADD = 4'h6, OP_SHL = 4'h7,
        OP_SHR = 4'h8, OP_SAR = 4'h9, OP_INV = 4'hA, OP_AND = 4'hB,
        OP_OR  = 4'hC, OP_XOR = 4'hD, OP_JMP = 4'hE, OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_OPND,
        S_OPINC,
        S_LD_MEM,
        S_ST_RD,
        S_ST_WR,
        S_ALU,
        S_LDR_S,
        S_JMP_S,
        S_HALT,
`ifdef CPU_CTRL_STEP_EN
        S_STEP,
`endif
        S_FAULT
    } state_e;

    // State that follows a completed instruction.
`ifdef CPU_CTRL_STEP_EN
    localparam state_e S_DONE = S_STEP;
`else
    localparam state_e S_DONE = S_FETCH;
`endif

    localparam logic [1:0] K_LAST     = 2'(OPND_BYTES - 1);
    localparam logic [7:0] TMO_LAST   = 8'(TMO - 1);
    localparam logic [2:0] FETCH_LAST = 3'(OPND_BYTES + 1);

    state_e     state_q, state_d;
    opcode_e    op_q, op_d;
    logic [1:0] k_q, k_d;
    logic [7:0] tmo_q, tmo_d;

    logic [OPW-1:0] ins_hi;
    logic           illegal;
    logic           wait_st;
    logic           tmo_hit;

    assign ins_hi  = ins >> 4;
    assign illegal = |ins_hi;
    assign wait_st = (state_q == S_FETCH) || (state_q == S_OPND) ||
                     (state_q == S_LD_MEM) || (state_q == S_ST_WR);
    // The counter holds the number of cycles already waited. Seeing TMO-1
    // with mem_rdy still low means this is the TMO-th cycle without a reply.
    // A reply in that same cycle still wins.
    assign tmo_hit = (tmo_q == TMO_LAST) && !mem_rdy;

    // State, latched opcode, operand byte index and wait counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            k_q     <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            k_q     <= k_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state, opcode latch, byte index and timeout counter logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (mem_rdy)      state_d = S_DECODE;
                else if (tmo_hit) state_d = S_FAULT;
            end
            S_DECODE: begin
                op_d = opcode_e'(ins[3:0]);
                k_d  = '0;
                if (illegal) begin
                    state_d = S_FAULT;
                end else begin
                    case (ins[3:0])
                        OP_NOP:                         state_d = S_DONE;
                        OP_HLT:                         state_d = S_HALT;
                        OP_LDR:                         state_d = S_LDR_S;
                        OP_LDO, OP_LDA, OP_STO, OP_JMP: state_d = S_OPND;
                        default:                        state_d = S_ALU;
                    endcase
                end
            end
            S_OPND: begin
                if (mem_rdy)      state_d = S_OPINC;
                else if (tmo_hit) state_d = S_FAULT;
            end
            S_OPINC: begin
                if (k_q != K_LAST) begin
                    k_d     = k_q + 2'd1;
                    state_d = S_OPND;
                end else begin
                    case (op_q)
                        OP_LDO, OP_LDA: state_d = S_LD_MEM;
                        OP_STO:         state_d = S_ST_RD;
                        OP_JMP:         state_d = S_JMP_S;
                        default:        state_d = S_IDLE;
                    endcase
                end
            end
            S_LD_MEM: begin
                if (mem_rdy)      state_d = S_DONE;
                else if (tmo_hit) state_d = S_FAULT;
            end
            S_ST_RD:  state_d = S_ST_WR;
            S_ST_WR: begin
                if (mem_rdy)      state_d = S_DONE;
                else if (tmo_hit) state_d = S_FAULT;
            end
            S_ALU:    state_d = S_DONE;
            S_LDR_S:  state_d = S_DONE;
            S_JMP_S:  state_d = S_DONE;
            S_HALT:   if (resume) state_d = S_DONE;
`ifdef CPU_CTRL_STEP_EN
            S_STEP:   if (resume) state_d = S_FETCH;
`endif
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_IDLE;
        endcase

        if (state_d != state_q)       tmo_d = '0;
        else if (wait_st && !mem_rdy) tmo_d = tmo_q + 8'd1;
        else                          tmo_d = tmo_q;
    end

    // Output strobes decoded from state and latched opcode only
    always_comb begin
        reg_write = 1'b0;
        reg_read  = 1'b0;
        rom_en    = 1'b0;
        rom_read  = 1'b0;
        ram_en    = 1'b0;
        ram_write = 1'b0;
        ram_read  = 1'b0;
        pc_en     = 1'b0;
        pc_chg_en = 1'b0;
        acc_en    = 1'b0;
        fetch     = 3'd0;
        addr_sel  = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;
        case (state_q)
            S_FETCH: begin
                rom_en   = 1'b1;
                rom_read = 1'b1;
                fetch    = 3'd1;
            end
            S_DECODE: begin
                rom_en   = 1'b1;
                rom_read = 1'b1;
                pc_en    = 1'b1;
            end
            S_OPND: begin
                rom_en   = 1'b1;
                rom_read = 1'b1;
                fetch    = 3'd2 + {1'b0, k_q};
            end
            S_OPINC:  pc_en = 1'b1;
            S_LD_MEM: begin
                reg_write = 1'b1;
                addr_sel  = 1'b1;
                if (op_q == OP_LDO) begin
                    rom_en   = 1'b1;
                    rom_read = 1'b1;
                end else begin
                    ram_en   = 1'b1;
                    ram_read = 1'b1;
                end
            end
            S_ST_RD:  reg_read = 1'b1;
            S_ST_WR: begin
                reg_read  = 1'b1;
                ram_en    = 1'b1;
                ram_write = 1'b1;
                addr_sel  = 1'b1;
            end
            S_ALU: begin
                reg_read = 1'b1;
                acc_en   = 1'b1;
            end
            S_LDR_S: begin
                reg_write = 1'b1;
                acc_en    = 1'b1;
            end
            S_JMP_S: begin
                pc_en     = 1'b1;
                pc_chg_en = 1'b1;
                fetch     = FETCH_LAST;
            end
            S_HALT:   halted = 1'b1;
`ifdef CPU_CTRL_STEP_EN
            S_STEP:   halted = 1'b1;
`endif
            S_FAULT:  fault = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Testbench for cpu_ctrl_seq.
// It builds a per-instruction list of expected strobe phases from the opcode
// rules, replays that list against the DUT with random wait and resume
// timing, and checks every cycle.
module tb_cpu_ctrl_seq;

    localparam int OPW        = 5;
    localparam int OPND_BYTES = 2;
    localparam int TMO        = 15;

    localparam logic [15:0] RW    = 16'h8000;
    localparam logic [15:0] RR    = 16'h4000;
    localparam logic [15:0] ROM   = 16'h3000;
    localparam logic [15:0] RAMEN = 16'h0800;
    localparam logic [15:0] RAMWR = 16'h0400;
    localparam logic [15:0] RAMRD = 16'h0200;
    localparam logic [15:0] PC    = 16'h0100;
    localparam logic [15:0] PCC   = 16'h0080;
    localparam logic [15:0] ACC   = 16'h0040;
    localparam logic [15:0] AS    = 16'h0004;
    localparam logic [15:0] HLTD  = 16'h0002;
    localparam logic [15:0] FLT   = 16'h0001;

    localparam int W_NONE = 0;
    localparam int W_MEM  = 1;
    localparam int W_RES  = 2;

    typedef struct {
        logic [15:0]    exp;
        int             kind;
        int             d;
        logic [OPW-1:0] insv;
        string          nm;
    } ph_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [OPW-1:0] ins = '0;
    logic           mem_rdy = 1'b0;
    logic           resume = 1'b0;
    logic           reg_write, reg_read, rom_en, rom_read, ram_en, ram_write, ram_read;
    logic           pc_en, pc_chg_en, acc_en, addr_sel, halted, fault;
    logic [2:0]     fetch;
    logic [15:0]    obs;

    int  tests  = 0;
    int  failed = 0;
    ph_t q[$];

    cpu_ctrl_seq #(.OPW(OPW), .OPND_BYTES(OPND_BYTES), .TMO(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .ins       (ins),
        .mem_rdy   (mem_rdy),
        .resume    (resume),
        .reg_write (reg_write),
        .reg_read  (reg_read),
        .rom_en    (rom_en),
        .rom_read  (rom_read),
        .ram_en    (ram_en),
        .ram_write (ram_write),
        .ram_read  (ram_read),
        .pc_en     (pc_en),
        .pc_chg_en (pc_chg_en),
        .acc_en    (acc_en),
        .fetch     (fetch),
        .addr_sel  (addr_sel),
        .halted    (halted),
        .fault     (fault)
    );

    assign obs = {reg_write, reg_read, rom_en, rom_read, ram_en, ram_write, ram_read,
                  pc_en, pc_chg_en, acc_en, fetch, addr_sel, halted, fault};

    always #5 clk = ~clk;

    function automatic logic [15:0] F(input int n);
        return 16'(n) << 3;
    endfunction

    function automatic logic [OPW-1:0] rins();
        return OPW'($urandom);
    endfunction

    function automatic int mdly(input int dsel);
        if (dsel >= 0) return dsel;
        if ($urandom_range(0, 5) == 0) return TMO - 1;
        return $urandom_range(0, 3);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_rdy = 1'b0;
        resume = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic push(input logic [15:0] e, input int kind, input int d,
                        input logic [OPW-1:0] iv, input string nm);
        ph_t p;
        p.exp  = e;
        p.kind = kind;
        p.d    = d;
        p.insv = iv;
        p.nm   = nm;
        q.push_back(p);
    endtask

    task automatic step_after();
`ifdef CPU_CTRL_STEP_EN
        push(HLTD, W_RES, $urandom_range(0, 3), rins(), "step");
`endif
    endtask

    // Expected phases of one instruction, starting from its opcode fetch
    task automatic model_instr(input logic [3:0] op, input int dsel);
        push(ROM | F(1), W_MEM, mdly(dsel), rins(), "fetch");
        push(ROM | PC, W_NONE, 0, OPW'(op), "decode");
        if (op == 4'hF) begin
            push(HLTD, W_RES, $urandom_range(0, 4), rins(), "halt");
            step_after();
        end else if (op == 4'h0) begin
            step_after();
        end else if (op == 4'h3) begin
            push(RW | ACC, W_NONE, 0, rins(), "ldr");
            step_after();
        end else if (op == 4'h1 || op == 4'h2 || op == 4'h5 || op == 4'hE) begin
            for (int k = 0; k < OPND_BYTES; k++) begin
                push(ROM | F(2 + k), W_MEM, mdly(dsel), rins(), "opnd");
                push(PC, W_NONE, 0, rins(), "opinc");
            end
            case (op)
                4'h1: push(RW | AS | ROM, W_MEM, mdly(dsel), rins(), "ld_rom");
                4'h2: push(RW | AS | RAMEN | RAMRD, W_MEM, mdly(dsel), rins(), "ld_ram");
                4'h5: begin
                    push(RR, W_NONE, 0, rins(), "st_rd");
                    push(RR | RAMEN | RAMWR | AS, W_MEM, mdly(dsel), rins(), "st_wr");
                end
                default: push(PC | PCC | F(OPND_BYTES + 1), W_NONE, 0, rins(), "jmp");
            endcase
            step_after();
        end else begin
            push(RR | ACC, W_NONE, 0, rins(), "alu");
            step_after();
        end
    endtask

    task automatic test_reset();
        tick();
        tests++;
        if (obs !== 16'h0) begin
            failed++;
            $display("FAIL reset_hold got=%h exp=%h", obs, 16'h0);
        end
        rst = 1'b0;
        tests++;
        if (obs !== 16'h0) begin
            failed++;
            $display("FAIL reset_idle got=%h exp=%h", obs, 16'h0);
        end
        tick();
        tests++;
        if (obs !== (ROM | F(1))) begin
            failed++;
            $display("FAIL reset_to_fetch got=%h exp=%h", obs, ROM | F(1));
        end
        // drive a store into its write wait state, then reset it there
        ins = OPW'(5);
        mem_rdy = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        mem_rdy = 1'b0;
        tests++;
        if (obs !== (RR | RAMEN | RAMWR | AS)) begin
            failed++;
            $display("FAIL reach_st_wr got=%h exp=%h", obs, RR | RAMEN | RAMWR | AS);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (obs !== 16'h0) begin
            failed++;
            $display("FAIL async_reset got=%h exp=%h", obs, 16'h0);
        end
        tick();
        rst = 1'b0;
        tick();
        tests++;
        if (obs !== (ROM | F(1))) begin
            failed++;
            $display("FAIL post_reset_fetch got=%h exp=%h", obs, ROM | F(1));
        end
    endtask

    task automatic test_sequences();
        ph_t p;
        int  n;
        model_instr(4'h6, 0);
        model_instr(4'hE, 0);
        model_instr(4'h2, 5);
        model_instr(4'hF, 0);
        model_instr(4'h0, 0);
        model_instr(4'h5, 0);
        for (int i = 0; i < 40; i++) model_instr(4'($urandom), -1);
        while (q.size() != 0) begin
            p = q.pop_front();
            n = (p.kind == W_NONE) ? 1 : p.d + 1;
            for (int c = 0; c < n; c++) begin
                ins     = p.insv;
                mem_rdy = (p.kind == W_MEM) ? (c == n - 1) : 1'($urandom_range(0, 1));
                resume  = (p.kind == W_RES) ? (c == n - 1) : 1'($urandom_range(0, 1));
                tests++;
                if (obs !== p.exp) begin
                    failed++;
                    $display("FAIL seq_%s cyc=%0d got=%h exp=%h", p.nm, c, obs, p.exp);
                end
                tick();
            end
        end
        mem_rdy = 1'b0;
        resume = 1'b0;
    endtask

    task automatic test_timeout();
        mem_rdy = 1'b0;
        for (int c = 0; c < TMO; c++) begin
            resume = 1'($urandom_range(0, 1));
            tests++;
            if (obs !== (ROM | F(1))) begin
                failed++;
                $display("FAIL tmo_wait cyc=%0d got=%h exp=%h", c, obs, ROM | F(1));
            end
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            resume = (c == 1);
            mem_rdy = 1'($urandom_range(0, 1));
            tests++;
            if (obs !== FLT) begin
                failed++;
                $display("FAIL tmo_fault cyc=%0d got=%h exp=%h", c, obs, FLT);
            end
            tick();
        end
        do_reset();
        tests++;
        if (obs !== (ROM | F(1))) begin
            failed++;
            $display("FAIL tmo_recover got=%h exp=%h", obs, ROM | F(1));
        end
    endtask

    task automatic test_illegal();
        logic [OPW-1:0] bad;
        bad = OPW'(5'h10 | 5'($urandom_range(0, 15)));
        ins = bad;
        mem_rdy = 1'b1;
        tick();
        tests++;
        if (obs !== (ROM | PC)) begin
            failed++;
            $display("FAIL illegal_decode got=%h exp=%h", obs, ROM | PC);
        end
        tick();
        for (int c = 0; c < 3; c++) begin
            resume = (c == 0);
            tests++;
            if (obs !== FLT) begin
                failed++;
                $display("FAIL illegal_fault ins=%h cyc=%0d got=%h exp=%h", bad, c, obs, FLT);
            end
            tick();
        end
        do_reset();
        tests++;
        if (obs !== (ROM | F(1))) begin
            failed++;
            $display("FAIL illegal_recover got=%h exp=%h", obs, ROM | F(1));
        end
    endtask

    initial begin
        test_reset();
        test_sequences();
        test_timeout();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
